// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped load, wrap/one-shot modes and cascade carry.
// Optional BCD view of the count on bcd_out when BCD_OUT_EN is defined.
module mod_updown_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MODULUS    = 100,
  parameter int unsigned ONE_SHOT   = 0,
  parameter int unsigned BCD_DIGITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
`ifdef BCD_OUT_EN
  ,
  output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  // Reject parameter sets whose count range cannot be represented.
  if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH) ||
      (BCD_DIGITS < 10 && (64'(10) ** BCD_DIGITS) < 64'(MODULUS))) begin : g_param_check
    $error("mod_updown_counter: illegal WIDTH/MODULUS/BCD_DIGITS combination");
  end

  logic             at_term;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             done_nxt;

  // Next-state and cascade carry; priority clr > load > en > hold.
  always_comb begin
    at_term   = up ? (count == TERM) : (count == '0);
    tc        = en & at_term & ~done;
    count_nxt = count;
    wrap_nxt  = 1'b0;
    done_nxt  = done;
    if (clr) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (load) begin
      count_nxt = ((WIDTH+1)'(load_val) >= (WIDTH+1)'(MODULUS)) ? TERM : load_val;
      done_nxt  = 1'b0;
    end else if (en && !done) begin
      if (!at_term) begin
        count_nxt = up ? count + WIDTH'(1) : count - WIDTH'(1);
      end else begin
        wrap_nxt = 1'b1;
        if (ONE_SHOT != 0) begin
          done_nxt = 1'b1;
        end else begin
          count_nxt = up ? '0 : TERM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      done  <= done_nxt;
    end
  end

`ifdef BCD_OUT_EN
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;

  // Shift-add-3 conversion, applied to the next count so bcd_out lines up with count.
  function automatic logic [BCD_W-1:0] to_bcd(input logic [WIDTH-1:0] bin);
    logic [BCD_W-1:0] b;
    b = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      for (int d = 0; d < int'(BCD_DIGITS); d++) begin
        if (b[4*d +: 4] >= 4'd5) b[4*d +: 4] = b[4*d +: 4] + 4'd3;
      end
      b = {b[BCD_W-2:0], bin[i]};
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_out <= '0;
    end else begin
      bcd_out <= to_bcd(count_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: random stimulus on a 0..99 counter, a one-shot 0..9 counter and a 60x60 cascade,
// expected responses from an arithmetic reference model queued and checked by a separate monitor.
module tb_mod_updown_counter;

  localparam int NCYC = 4400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: MODULUS 100 wrap, b: MODULUS 10 one-shot, s/m: seconds/minutes cascade
  logic       a_rst, a_en, a_up, a_clr, a_load, a_tc, a_wrap, a_done;
  logic [7:0] a_lv, a_cnt;
  logic       b_rst, b_en, b_up, b_clr, b_load, b_tc, b_wrap, b_done;
  logic [3:0] b_lv, b_cnt;
  logic       s_rst, s_en, s_up, s_clr, s_load, s_tc, s_wrap, s_done;
  logic [5:0] s_lv, s_cnt;
  logic       m_tc, m_wrap, m_done;
  logic [5:0] m_cnt;
`ifdef BCD_OUT_EN
  logic [7:0] a_bcd, s_bcd, m_bcd;
  logic [3:0] b_bcd;
`endif

  mod_updown_counter #(.WIDTH(8), .MODULUS(100), .ONE_SHOT(0), .BCD_DIGITS(2)) u_a (
    .clk(clk), .reset(a_rst), .en(a_en), .up(a_up), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .count(a_cnt), .tc(a_tc), .wrap(a_wrap), .done(a_done)
`ifdef BCD_OUT_EN
    , .bcd_out(a_bcd)
`endif
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1), .BCD_DIGITS(1)) u_b (
    .clk(clk), .reset(b_rst), .en(b_en), .up(b_up), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .count(b_cnt), .tc(b_tc), .wrap(b_wrap), .done(b_done)
`ifdef BCD_OUT_EN
    , .bcd_out(b_bcd)
`endif
  );

  mod_updown_counter #(.WIDTH(6), .MODULUS(60), .ONE_SHOT(0), .BCD_DIGITS(2)) u_sec (
    .clk(clk), .reset(s_rst), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load), .load_val(s_lv),
    .count(s_cnt), .tc(s_tc), .wrap(s_wrap), .done(s_done)
`ifdef BCD_OUT_EN
    , .bcd_out(s_bcd)
`endif
  );

  mod_updown_counter #(.WIDTH(6), .MODULUS(60), .ONE_SHOT(0), .BCD_DIGITS(2)) u_min (
    .clk(clk), .reset(s_rst), .en(s_tc), .up(s_up), .clr(s_clr), .load(s_load), .load_val(s_lv),
    .count(m_cnt), .tc(m_tc), .wrap(m_wrap), .done(m_done)
`ifdef BCD_OUT_EN
    , .bcd_out(m_bcd)
`endif
  );

  typedef struct {
    int ca; bit wa; bit da; bit ta;
    int cb; bit wb; bit db; bit tb;
    int cs; bit ws; bit ts;
    int cm; bit wm; bit tm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: modular arithmetic over 0..m-1; pre-edge carry and post-edge state.
  function automatic void model(input int m, input bit os, input bit rst, input bit clr,
                                input bit ld, input bit en, input bit up, input int lv,
                                input int cur, input bit dn,
                                output int nxt, output bit ndn, output bit wr, output bit tc);
    bit hit_end;
    hit_end = up ? (cur == m - 1) : (cur == 0);
    tc  = en && !dn && hit_end;
    nxt = cur;
    ndn = dn;
    wr  = 1'b0;
    if (rst) begin
      nxt = 0; ndn = 1'b0;
    end else if (clr) begin
      nxt = 0; ndn = 1'b0;
    end else if (ld) begin
      nxt = (lv < m) ? lv : m - 1; ndn = 1'b0;
    end else if (en && !dn) begin
      wr = hit_end;
      if (hit_end && os) ndn = 1'b1;
      else nxt = up ? (cur + 1) % m : (cur + m - 1) % m;
    end
  endfunction

  // Stimulus: drive at negedge, model the coming edge, queue the expectation.
  initial begin
    int ca, cb, cs, cm;
    bit da, db, ds, dm, dummy_w;
    exp_t e;
    {a_rst, b_rst, s_rst} = 3'b111;
    {a_en, a_up, a_clr, a_load, b_en, b_up, b_clr, b_load, s_en, s_up, s_clr, s_load} = '0;
    a_lv = '0; b_lv = '0; s_lv = '0;
    ca = 0; cb = 0; cs = 0; cm = 0; da = 0; db = 0; ds = 0; dm = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_count", 32'(a_cnt), 0);
    chk("reset_wrap", 32'(a_wrap), 0);
    chk("reset_done", 32'(b_done), 0);
    for (int k = 0; k < NCYC; k++) begin
      if (k > 0) @(negedge clk);
      // counter a: full up lap, directed down-wrap/hold/load/clamp/clr cases, then random
      {a_rst, a_clr, a_load} = 3'b000; a_lv = '0;
      if (k < 100) begin a_en = 1; a_up = 1; end
      else if (k == 100) begin a_en = 1; a_up = 0; end
      else if (k == 101) begin a_en = 0; a_up = 1; end
      else if (k == 102) begin a_en = 1; a_load = 1; a_lv = 8'd42; end
      else if (k == 103) begin a_en = 1; a_load = 1; a_lv = 8'd150; end
      else if (k == 104) begin a_en = 1; a_clr = 1; a_load = 1; a_lv = 8'd7; end
      else if (k >= 105 && k < 162) begin a_en = 1; a_up = 1; end
      else if (k == 162) begin a_en = 1; a_load = 1; a_rst = 1; end
      else begin
        a_rst  = ($urandom_range(63) == 0);
        a_clr  = ($urandom_range(31) == 0);
        a_load = ($urandom_range(15) == 0);
        a_en   = ($urandom_range(3) != 0);
        a_up   = 1'($urandom_range(1));
        a_lv   = 8'($urandom_range(255));
      end
      // counter b: run into the one-shot stop, poke en, clear, then random
      {b_rst, b_clr, b_load} = 3'b000; b_lv = '0;
      if (k < 16) begin b_en = 1; b_up = 1; end
      else if (k == 16) begin b_en = 1; b_clr = 1; end
      else begin
        b_rst  = ($urandom_range(63) == 0);
        b_clr  = ($urandom_range(31) == 0);
        b_load = ($urandom_range(15) == 0);
        b_en   = ($urandom_range(3) != 0);
        b_up   = 1'($urandom_range(1));
        b_lv   = 4'($urandom_range(15));
      end
      // cascade: one hour of ticks, then random
      {s_rst, s_clr, s_load} = 3'b000; s_lv = '0;
      if (k < 3600) begin s_en = 1; s_up = 1; end
      else begin
        s_rst  = ($urandom_range(255) == 0);
        s_clr  = ($urandom_range(127) == 0);
        s_load = ($urandom_range(63) == 0);
        s_en   = ($urandom_range(3) != 0);
        s_up   = 1'($urandom_range(1));
        s_lv   = 6'($urandom_range(63));
      end

      model(100, 1'b0, a_rst, a_clr, a_load, a_en, a_up, int'(a_lv), ca, da, e.ca, e.da, e.wa, e.ta);
      model(10, 1'b1, b_rst, b_clr, b_load, b_en, b_up, int'(b_lv), cb, db, e.cb, e.db, e.wb, e.tb);
      model(60, 1'b0, s_rst, s_clr, s_load, s_en, s_up, int'(s_lv), cs, ds, e.cs, ds, e.ws, e.ts);
      model(60, 1'b0, s_rst, s_clr, s_load, e.ts, s_up, int'(s_lv), cm, dm, e.cm, dm, e.wm, e.tm);
      ca = e.ca; da = e.da; cb = e.cb; db = e.db; cs = e.cs; cm = e.cm;
      dummy_w = e.wm;
      q.push_back(e);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: carry checked before the edge, registered outputs #1 after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("a_tc", 32'(a_tc), 32'(e.ta));
        chk("b_tc", 32'(b_tc), 32'(e.tb));
        chk("sec_tc", 32'(s_tc), 32'(e.ts));
        chk("min_tc", 32'(m_tc), 32'(e.tm));
        @(posedge clk);
        #1;
        chk("a_count", 32'(a_cnt), 32'(e.ca));
        chk("a_wrap", 32'(a_wrap), 32'(e.wa));
        chk("a_done", 32'(a_done), 0);
        chk("b_count", 32'(b_cnt), 32'(e.cb));
        chk("b_wrap", 32'(b_wrap), 32'(e.wb));
        chk("b_done", 32'(b_done), 32'(e.db));
        chk("sec_count", 32'(s_cnt), 32'(e.cs));
        chk("sec_wrap", 32'(s_wrap), 32'(e.ws));
        chk("min_count", 32'(m_cnt), 32'(e.cm));
        chk("min_wrap", 32'(m_wrap), 32'(e.wm));
`ifdef BCD_OUT_EN
        chk("a_bcd", 32'(a_bcd), 32'(((e.ca / 10) << 4) | (e.ca % 10)));
        chk("b_bcd", 32'(b_bcd), 32'(e.cb));
        chk("sec_bcd", 32'(s_bcd), 32'(((e.cs / 10) << 4) | (e.cs % 10)));
        chk("min_bcd", 32'(m_bcd), 32'(((e.cm / 10) << 4) | (e.cm % 10)));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
